// File: rtl/uart_axil_regbank.sv
// AXI4-Lite register bank fronting a UART transmitter: CTRL, LENGTH, STATUS and scratch registers.
// Define UART_AXIL_IRQ_EN to add the CTRL.IRQ_EN bit and the registered irq_o output.
module uart_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 8,
    parameter int C_LEN_WIDTH        = 10
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_LEN_WIDTH-1:0]          data_length_o,
    output logic                            sent_trig_o,
    input  logic                            tx_busy_i,
    input  logic                            tx_done_i
`ifdef UART_AXIL_IRQ_EN
    ,
    output logic                            irq_o
`endif
);
    localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM
    // state    | meaning
    // WR_INIT  | first cycle after reset, nothing accepted yet
    // WR_IDLE  | no address or data held
    // WR_ADDR  | address held, waiting for data
    // WR_DATA  | data held, waiting for address
    // WR_BOTH  | both held, register update happens at the next edge
    // WR_RESP  | BVALID high until BREADY
    typedef enum logic [2:0] {
        WR_INIT, WR_IDLE, WR_ADDR, WR_DATA, WR_BOTH, WR_RESP
    } wr_state_t;

    wr_state_t wr_state, wr_next;
    logic aw_ready, w_ready, b_valid, commit;
    logic aw_hs, w_hs, ar_hs, ar_ready;

    logic [IDXW-1:0] wr_idx;
    logic [31:0]     w_data_q;
    logic [3:0]      w_strb_q;
    logic [1:0]      b_resp_q;

    logic [C_LEN_WIDTH-1:0] len_q;
    logic [31:0]            len_ext;
    logic                   done_q, ovr_q, sent_trig_q, ctrl_irq_en;
    logic [31:0]            scratch_q [3:C_NUM_REGS-1];

    logic            wr_ok, send_req, clr_done, clr_ovr;
    logic [IDXW-1:0] rd_idx;
    logic            rd_ok;
    logic [31:0]     rd_val, r_data_q;
    logic            r_valid_q;
    logic [1:0]      r_resp_q;
    logic            unused_bits;

    assign aw_hs = S_AXI_AWVALID && aw_ready;
    assign w_hs  = S_AXI_WVALID && w_ready;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) wr_state <= WR_INIT;
        else              wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_INIT: wr_next = WR_IDLE;
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_next = WR_BOTH;
                else if (aw_hs)    wr_next = WR_ADDR;
                else if (w_hs)     wr_next = WR_DATA;
            end
            WR_ADDR: if (w_hs)  wr_next = WR_BOTH;
            WR_DATA: if (aw_hs) wr_next = WR_BOTH;
            WR_BOTH: wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        commit   = 1'b0;
        case (wr_state)
            WR_IDLE: begin aw_ready = 1'b1; w_ready = 1'b1; end
            WR_ADDR: w_ready  = 1'b1;
            WR_DATA: aw_ready = 1'b1;
            WR_BOTH: commit   = 1'b1;
            WR_RESP: b_valid  = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        wr_ok    = int'(wr_idx) < C_NUM_REGS;
        send_req = commit && (wr_idx == IDXW'(0)) && w_strb_q[0] && w_data_q[0];
        clr_done = commit && (wr_idx == IDXW'(2)) && w_strb_q[0] && w_data_q[1];
        clr_ovr  = commit && (wr_idx == IDXW'(2)) && w_strb_q[0] && w_data_q[2];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_idx      <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            b_resp_q    <= RESP_OKAY;
            len_q       <= '0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            sent_trig_q <= 1'b0;
            for (int i = 3; i < C_NUM_REGS; i++) scratch_q[i] <= '0;
        end else begin
            if (aw_hs) wr_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data_q <= 32'(S_AXI_WDATA);
                w_strb_q <= 4'(S_AXI_WSTRB);
            end
            sent_trig_q <= send_req && !tx_busy_i;
            // A completion pulse beats a coincident write-1-to-clear.
            done_q <= tx_done_i || (done_q && !clr_done);
            ovr_q  <= (send_req && tx_busy_i) || (ovr_q && !clr_ovr);
            if (commit) begin
                b_resp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_idx == IDXW'(1)) begin
                    for (int j = 0; j < C_LEN_WIDTH; j++)
                        if (w_strb_q[j/8]) len_q[j] <= w_data_q[j];
                end
                for (int i = 3; i < C_NUM_REGS; i++)
                    if (wr_idx == IDXW'(i))
                        scratch_q[i] <= merge(scratch_q[i], w_data_q, w_strb_q);
            end
        end
    end

`ifdef UART_AXIL_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (commit && (wr_idx == IDXW'(0)) && w_strb_q[0]) irq_en_q <= w_data_q[1];
            irq_q <= irq_en_q && (done_q || ovr_q);
        end
    end

    assign ctrl_irq_en = irq_en_q;
    assign irq_o       = irq_q;
`else
    assign ctrl_irq_en = 1'b0;
`endif

    assign rd_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_ready = !r_valid_q && (wr_state != WR_INIT);
    assign ar_hs    = S_AXI_ARVALID && ar_ready;

    always_comb begin
        len_ext = '0;
        len_ext[C_LEN_WIDTH-1:0] = len_q;
        rd_ok  = int'(rd_idx) < C_NUM_REGS;
        rd_val = '0;
        if (rd_idx == IDXW'(0))      rd_val = {30'd0, ctrl_irq_en, 1'b0};
        else if (rd_idx == IDXW'(1)) rd_val = len_ext;
        else if (rd_idx == IDXW'(2)) rd_val = {29'd0, ovr_q, done_q, tx_busy_i};
        else begin
            for (int i = 3; i < C_NUM_REGS; i++)
                if (rd_idx == IDXW'(i)) rd_val = scratch_q[i];
        end
    end

    // Sampled at the AR edge, so a same-edge write commit is not yet visible.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_data_q  <= rd_val;
            r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_valid_q && S_AXI_RREADY) begin
            r_valid_q <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_data_q);
    assign S_AXI_RRESP   = r_resp_q;
    assign data_length_o = len_q;
    assign sent_trig_o   = sent_trig_q;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_uart_axil_regbank.sv
// Directed bench for uart_axil_regbank: table of write/read-back vectors plus hand-timed sequences.
module tb_uart_axil_regbank;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [9:0]  data_length;
    logic        sent_trig, tx_busy, tx_done;
`ifdef UART_AXIL_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_IRQ = 32'h2;
`else
    localparam logic [31:0] CTRL_IRQ = 32'h0;
`endif

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;

    uart_axil_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .data_length_o(data_length), .sent_trig_o(sent_trig),
        .tx_busy_i(tx_busy), .tx_done_i(tx_done)
`ifdef UART_AXIL_IRQ_EN
        , .irq_o(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sent_trig) trig_cnt <= trig_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout got=no_handshake exp=handshake", name);
    endtask

    // All tasks start and end at a negedge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_ok = 0, w_ok = 0, fa, fw;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            fa = awvalid && awready;
            fw = wvalid && wready;
            @(posedge clk); @(negedge clk);
            if (fa) begin awvalid = 0; aw_ok = 1; end
            if (fw) begin wvalid = 0; w_ok = 1; end
            n++;
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        resp = 2'b11;
        if (!bvalid || !aw_ok || !w_ok) timeout("axi_write");
        else begin
            resp = bresp;
            bready = 1;
            @(posedge clk); @(negedge clk);
            bready = 0;
        end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0, f;
        int n = 0;
        araddr = a; arvalid = 1; rready = 0;
        while (!ok && n < 20) begin
            f = arready;
            @(posedge clk); @(negedge clk);
            if (f) ok = 1;
            n++;
        end
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        d = 32'hxxxx_xxxx; resp = 2'b11;
        if (!rvalid || !ok) timeout("axi_read");
        else begin
            d = rdata; resp = rresp;
            rready = 1;
            @(posedge clk); @(negedge clk);
            rready = 0;
        end
    endtask

    typedef struct {
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [5:0]  raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [9:0]  len;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int n;

        vecs[0]  = '{6'h04, 32'h0000_03FF, 4'hF, 2'b00, 6'h04, 32'h0000_03FF, 2'b00, 10'h3FF};
        vecs[1]  = '{6'h04, 32'hFFFF_FFFF, 4'hF, 2'b00, 6'h04, 32'h0000_03FF, 2'b00, 10'h3FF};
        vecs[2]  = '{6'h04, 32'h0000_0155, 4'h1, 2'b00, 6'h04, 32'h0000_0355, 2'b00, 10'h355};
        vecs[3]  = '{6'h10, 32'h1234_5678, 4'hF, 2'b00, 6'h10, 32'h1234_5678, 2'b00, 10'h355};
        vecs[4]  = '{6'h14, 32'hDEAD_BEEF, 4'hC, 2'b00, 6'h14, 32'hDEAD_0000, 2'b00, 10'h355};
        vecs[5]  = '{6'h1C, 32'hCAFE_F00D, 4'h0, 2'b00, 6'h1C, 32'h0000_0000, 2'b00, 10'h355};
        vecs[6]  = '{6'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, 6'h20, 32'h0000_0000, 2'b10, 10'h355};
        vecs[7]  = '{6'h3C, 32'hFFFF_FFFF, 4'hF, 2'b10, 6'h10, 32'h1234_5678, 2'b00, 10'h355};
        vecs[8]  = '{6'h18, 32'h0BAD_F00D, 4'h5, 2'b00, 6'h18, 32'h00AD_000D, 2'b00, 10'h355};
        vecs[9]  = '{6'h00, 32'h0000_0000, 4'hF, 2'b00, 6'h00, 32'h0000_0000, 2'b00, 10'h355};
        vecs[10] = '{6'h00, 32'h0000_0002, 4'hF, 2'b00, 6'h00, CTRL_IRQ,     2'b00, 10'h355};

        rst = 1; awaddr = 0; araddr = 0; awprot = 3'b010; arprot = 3'b001;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = 0; wstrb = 0; tx_busy = 0; tx_done = 0;

        // reset values, then readies one cycle after release
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp_rresp", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_trig", sent_trig, 0);
        chk("rst_len", data_length, 0);
        rst = 0;
        @(negedge clk);
        chk("rel_readies", {awready, wready, arready}, 3'b111);

        // REQ-026 latency: AW and W together, BVALID exactly one edge later
        awaddr = 6'h04; wdata = 32'h3FF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("lat_bvalid_early", bvalid, 0);
        @(negedge clk);
        chk("lat_bvalid", bvalid, 1);
        chk("lat_bresp", bresp, 0);
        chk("lat_len", data_length, 10'h3FF);
        bready = 1; @(posedge clk); @(negedge clk); bready = 0;

        for (int i = 0; i < 11; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, r);
            chk($sformatf("vec%0d_bresp", i), r, vecs[i].bresp);
            axi_read(vecs[i].raddr, d, r);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            chk($sformatf("vec%0d_rresp", i), r, vecs[i].rresp);
            chk($sformatf("vec%0d_len", i), data_length, vecs[i].len);
        end

        // W first, AW three cycles later
        wdata = 32'hA5A5_A5A5; wstrb = 4'h3; wvalid = 1;
        @(posedge clk); @(negedge clk);
        wvalid = 0;
        repeat (2) @(negedge clk);
        chk("wfirst_wready_blocked", wready, 0);
        chk("wfirst_no_bvalid", bvalid, 0);
        awaddr = 6'h0C; awvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        chk("wfirst_bvalid_early", bvalid, 0);
        @(negedge clk);
        chk("wfirst_bvalid", bvalid, 1);
        bready = 1; @(posedge clk); @(negedge clk); bready = 0;
        axi_read(6'h0C, d, r);
        chk("wfirst_rdata", d, 32'h0000_A5A5);

        // read in the commit cycle of a write to the same register returns the old value
        awaddr = 6'h10; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; araddr = 6'h10; arvalid = 1;
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        chk("rdw_rvalid", rvalid, 1);
        chk("rdw_rdata_old", rdata, 32'h1234_5678);
        chk("rdw_bvalid", bvalid, 1);
        bready = 1; rready = 1; @(posedge clk); @(negedge clk); bready = 0; rready = 0;
        axi_read(6'h10, d, r);
        chk("rdw_rdata_new", d, 32'h1111_1111);

        // SEND with idle transmitter: one single-cycle pulse
        tx_busy = 0;
        axi_write(6'h00, 32'h1, 4'hF, r);
        repeat (3) @(negedge clk);
        chk("send_pulse_cnt", trig_cnt, 1);
        axi_read(6'h00, d, r);
        chk("ctrl_send_reads0", d, 0);
        // SEND while busy: no pulse, overrun flagged
        tx_busy = 1;
        axi_write(6'h00, 32'h1, 4'hF, r);
        repeat (3) @(negedge clk);
        chk("busy_pulse_cnt", trig_cnt, 1);
        axi_read(6'h08, d, r);
        chk("busy_status", d, 32'h5);
        tx_busy = 0;

        // W1C of OVR, then DONE set by tx_done, then W1C racing tx_done
        axi_write(6'h08, 32'h4, 4'hF, r);
        axi_read(6'h08, d, r);
        chk("ovr_cleared", d, 0);
        axi_write(6'h00, 32'h2, 4'hF, r);
        tx_done = 1; @(negedge clk); tx_done = 0;
        axi_read(6'h08, d, r);
        chk("done_set", d, 32'h2);
        awaddr = 6'h08; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        chk("race_bvalid", bvalid, 1);
        bready = 1; @(posedge clk); @(negedge clk); bready = 0;
        axi_read(6'h08, d, r);
        chk("race_done_kept", d, 32'h2);
`ifdef UART_AXIL_IRQ_EN
        chk("race_irq", irq, 1);
`endif
        axi_write(6'h08, 32'h2, 4'hF, r);
        axi_read(6'h08, d, r);
        chk("done_cleared", d, 0);
`ifdef UART_AXIL_IRQ_EN
        chk("irq_cleared", irq, 0);
`endif

        // responses held stable while BREADY/RREADY stay low
        awaddr = 6'h14; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 6'h14; arvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_bvalid", c), bvalid, 1);
            chk($sformatf("stall%0d_bresp", c), bresp, 0);
            chk($sformatf("stall%0d_rvalid", c), rvalid, 1);
            chk($sformatf("stall%0d_rdata", c), rdata, 32'hDEAD_0000);
            chk($sformatf("stall%0d_ready", c), {awready, wready, arready}, 0);
            @(negedge clk);
        end
        bready = 1; rready = 1; @(posedge clk); @(negedge clk); bready = 0; rready = 0;
        axi_read(6'h14, d, r);
        chk("stall_after", d, 32'h0F0F_0F0F);

        // reset with an address held: the address must be dropped
        awaddr = 6'h10; awvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst2_len", data_length, 0);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); @(negedge clk);
        wvalid = 0;
        repeat (3) begin
            chk("rst2_no_commit", bvalid, 0);
            @(negedge clk);
        end
        awaddr = 6'h10; awvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        n = 0;
        while (!bvalid && n < 10) begin @(negedge clk); n++; end
        if (!bvalid) timeout("rst2_bvalid");
        bready = 1; @(posedge clk); @(negedge clk); bready = 0;
        axi_read(6'h10, d, r);
        chk("rst2_scratch", d, 32'h55);
        axi_read(6'h14, d, r);
        chk("rst2_scratch_cleared", d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
